// File: rtl/cpu_pkg.sv
// Shared CPU definitions: machine-cycle phase encodings, opcodes and the
// run-control state encoding used by phase_sequencer and the controller.
package cpu_pkg;

  localparam int unsigned PHASE_W  = 3;
  localparam int unsigned OPCODE_W = 4;

  // Machine-cycle phases; the controller decodes these directly.
  localparam logic [PHASE_W-1:0] PHASE_INST_ADDR  = 3'd0;
  localparam logic [PHASE_W-1:0] PHASE_INST_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] PHASE_DECODE     = 3'd2;
  localparam logic [PHASE_W-1:0] PHASE_OPER_ADDR  = 3'd3;
  localparam logic [PHASE_W-1:0] PHASE_EXECUTE    = 3'd4;
  localparam logic [PHASE_W-1:0] PHASE_MEM_ADDR   = 3'd5;
  localparam logic [PHASE_W-1:0] PHASE_MEM_READ   = 3'd6;
  localparam logic [PHASE_W-1:0] PHASE_STORE      = 3'd7;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_RUN    = 2'd1,
    SEQ_STEP   = 2'd2,
    SEQ_HALTED = 2'd3
  } seq_state_e;

  // Phase advance with natural 7 -> 0 wrap.
  function automatic logic [PHASE_W-1:0] phase_next(input logic [PHASE_W-1:0] p);
    return PHASE_W'(p + 3'd1);
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter; wraps silently at full scale.
module retire_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_en) count_d = CNT_W'(count_q + CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/phase_sequencer.sv
// Machine-cycle phase generator and CPU run control (idle/run/stop/halt).
// Define PHASE_STEP_EN to add the step port and single-instruction STEP mode.
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
`ifdef PHASE_STEP_EN
  input  logic               step,
`endif
  input  logic               halt,
  output logic [PHASE_W-1:0] phase,
  output logic               running,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  seq_state_e         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               stop_pend_q, stop_pend_d;
  logic               halted_q, halted_d;
  logic               running_q, running_d;
  logic               retire_inc_c;

  // Next-state, phase and run-control flags.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    stop_pend_d  = stop_pend_q;
    halted_d     = halted_q;
    retire_inc_c = 1'b0;

    case (state_q)
      SEQ_IDLE, SEQ_HALTED: begin
        phase_d = PHASE_INST_ADDR;
        if (start) begin
          state_d     = SEQ_RUN;
          halted_d    = 1'b0;
          stop_pend_d = stop;
        end
`ifdef PHASE_STEP_EN
        else if (step) begin
          state_d  = SEQ_STEP;
          halted_d = 1'b0;
        end
`endif
      end

      SEQ_RUN, SEQ_STEP: begin
        if ((phase_q == PHASE_EXECUTE) && halt) begin
          state_d      = SEQ_HALTED;
          phase_d      = PHASE_INST_ADDR;
          retire_inc_c = 1'b1;
          halted_d     = 1'b1;
          stop_pend_d  = 1'b0;
        end else if (phase_q == PHASE_STORE) begin
          // Instruction boundary: a stop arriving on this very edge still counts.
          phase_d      = PHASE_INST_ADDR;
          retire_inc_c = 1'b1;
          if (state_q == SEQ_STEP) begin
            state_d = SEQ_IDLE;
          end else if (stop_pend_q || stop) begin
            state_d     = SEQ_IDLE;
            stop_pend_d = 1'b0;
          end
        end else begin
          phase_d = phase_next(phase_q);
          if ((state_q == SEQ_RUN) && stop) stop_pend_d = 1'b1;
        end
      end

      default: begin
        state_d = SEQ_IDLE;
        phase_d = PHASE_INST_ADDR;
      end
    endcase

    running_d = (state_d == SEQ_RUN) || (state_d == SEQ_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      phase_q     <= PHASE_INST_ADDR;
      stop_pend_q <= 1'b0;
      halted_q    <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      stop_pend_q <= stop_pend_d;
      halted_q    <= halted_d;
      running_q   <= running_d;
    end
  end

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (retire_inc_c),
    .count  (retired)
  );

  assign phase   = phase_q;
  assign running = running_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer; a narrow counter makes the wrap reachable.
module tb_phase_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] RMAX = '1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             halt;
`ifdef PHASE_STEP_EN
  logic             step_i;
`endif
  logic [2:0]       phase;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] retired;

  phase_sequencer #(
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
`ifdef PHASE_STEP_EN
    .step    (step_i),
`endif
    .halt    (halt),
    .phase   (phase),
    .running (running),
    .halted  (halted),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       ph;
    logic             run;
    logic             hlt;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t             sb_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] r;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] ph, input logic run, input logic hlt,
                      input logic [CNT_W-1:0] ret);
    exp_t e;
    e.ph  = ph;
    e.run = run;
    e.hlt = hlt;
    e.ret = ret;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of inputs, then compare the post-edge outputs to the oldest expectation.
  task automatic tick(input logic st, input logic sp, input logic h);
    exp_t e;
    start = st;
    stop  = sp;
    halt  = h;
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("phase",   32'(phase),   32'(e.ph));
      check_eq("running", 32'(running), 32'(e.run));
      check_eq("halted",  32'(halted),  32'(e.hlt));
      check_eq("retired", 32'(retired), 32'(e.ret));
    end else begin
      check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
    end
    start = 1'b0;
    stop  = 1'b0;
    halt  = 1'b0;
`ifdef PHASE_STEP_EN
    step_i = 1'b0;
`endif
  endtask

  // Running phases lo..hi of one instruction with no boundary in between.
  task automatic run_phases(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) begin
      push(3'(p), 1'b1, 1'b0, r);
      tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_phase"},   32'(phase),   32'd0);
    check_eq({tag, "_running"}, 32'(running), 32'd0);
    check_eq({tag, "_halted"},  32'(halted),  32'd0);
    check_eq({tag, "_retired"}, 32'(retired), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    halt  = 1'b0;
`ifdef PHASE_STEP_EN
    step_i = 1'b0;
`endif
    r = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Start, two full instructions, then HLT in phase 4 of the third.
    push(3'd0, 1'b1, 1'b0, r); tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      run_phases(1, 7);
      r = r + 1'b1;
      push(3'd0, 1'b1, 1'b0, r); tick(1'b0, 1'b0, 1'b0);
    end
    run_phases(1, 4);
    r = r + 1'b1;
    push(3'd0, 1'b0, 1'b1, r); tick(1'b0, 1'b0, 1'b1);
    push(3'd0, 1'b0, 1'b1, r); tick(1'b0, 1'b0, 1'b0);
    check_eq("retired_after_hlt", 32'(retired), 32'd3);

    // Resume; halt outside phase 4 ignored; stop in phase 2 ends at the boundary.
    push(3'd0, 1'b1, 1'b0, r); tick(1'b1, 1'b0, 1'b0);
    push(3'd1, 1'b1, 1'b0, r); tick(1'b0, 1'b0, 1'b0);
    push(3'd2, 1'b1, 1'b0, r); tick(1'b0, 1'b0, 1'b1);
    push(3'd3, 1'b1, 1'b0, r); tick(1'b0, 1'b1, 1'b0);
    run_phases(4, 7);
    r = r + 1'b1;
    push(3'd0, 1'b0, 1'b0, r); tick(1'b0, 1'b0, 1'b0);
    push(3'd0, 1'b0, 1'b0, r); tick(1'b0, 1'b1, 1'b0);
    push(3'd0, 1'b0, 1'b0, r); tick(1'b0, 1'b0, 1'b0);
    check_eq("retired_after_stop", 32'(retired), 32'd4);

    // start+stop together in IDLE: exactly one instruction.
    push(3'd0, 1'b1, 1'b0, r); tick(1'b1, 1'b1, 1'b0);
    run_phases(1, 7);
    r = r + 1'b1;
    push(3'd0, 1'b0, 1'b0, r); tick(1'b0, 1'b0, 1'b0);
    push(3'd0, 1'b0, 1'b0, r); tick(1'b0, 1'b0, 1'b0);
    check_eq("retired_start_stop", 32'(retired), 32'd5);
    check_eq("sb_drain_a", 32'(sb_q.size()), 32'd0);

    // Run to full-scale count, then async reset in the middle of phase 5.
    push(3'd0, 1'b1, 1'b0, r); tick(1'b1, 1'b0, 1'b0);
    while (r != RMAX) begin
      run_phases(1, 7);
      r = r + 1'b1;
      push(3'd0, 1'b1, 1'b0, r); tick(1'b0, 1'b0, 1'b0);
    end
    run_phases(1, 5);
    check_eq("retired_full", 32'(retired), 32'(RMAX));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r = '0;
    push(3'd0, 1'b0, 1'b0, r); tick(1'b0, 1'b0, 1'b0);

    // Full-scale wrap: 2^CNT_W instructions bring retired back to 0.
    push(3'd0, 1'b1, 1'b0, r); tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < (1 << CNT_W); i++) begin
      run_phases(1, 7);
      r = r + 1'b1;
      push(3'd0, 1'b1, 1'b0, r); tick(1'b0, 1'b0, 1'b0);
    end
    check_eq("retired_wrap", 32'(retired), 32'd0);
    push(3'd1, 1'b1, 1'b0, r); tick(1'b0, 1'b1, 1'b0);
    run_phases(2, 7);
    r = r + 1'b1;
    push(3'd0, 1'b0, 1'b0, r); tick(1'b0, 1'b0, 1'b0);

`ifdef PHASE_STEP_EN
    // HALT, then step once to IDLE, then step again and halt in phase 4.
    push(3'd0, 1'b1, 1'b0, r); tick(1'b1, 1'b0, 1'b0);
    run_phases(1, 4);
    r = r + 1'b1;
    push(3'd0, 1'b0, 1'b1, r); tick(1'b0, 1'b0, 1'b1);
    step_i = 1'b1;
    push(3'd0, 1'b1, 1'b0, r); tick(1'b0, 1'b0, 1'b0);
    run_phases(1, 7);
    r = r + 1'b1;
    push(3'd0, 1'b0, 1'b0, r); tick(1'b0, 1'b0, 1'b0);
    push(3'd0, 1'b0, 1'b0, r); tick(1'b0, 1'b0, 1'b0);
    step_i = 1'b1;
    push(3'd0, 1'b1, 1'b0, r); tick(1'b0, 1'b0, 1'b0);
    run_phases(1, 4);
    r = r + 1'b1;
    push(3'd0, 1'b0, 1'b1, r); tick(1'b0, 1'b0, 1'b1);
    push(3'd0, 1'b0, 1'b1, r); tick(1'b0, 1'b0, 1'b0);
`endif

    check_eq("sb_drain_end", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
